// File: rtl/dds_pkg.sv
// dds_pkg: waveform mode encoding and quarter-wave sine table generator
package dds_pkg;

    typedef enum logic [1:0] {
        MODE_SINE = 2'd0,
        MODE_SAW  = 2'd1,
        MODE_SQR  = 2'd2,
        MODE_TRI  = 2'd3
    } mode_t;

    // One quarter-wave entry: round((2**(out_w-1)-1) * sin(pi/2 * i / (2**lut_aw-1)))
    function automatic int sine_rom_entry(input int lut_aw, input int out_w, input int i);
        real amp;
        real x;
        amp = real'((1 << (out_w - 1)) - 1);
        x = 1.5707963267948966 * real'(i) / real'((1 << lut_aw) - 1);
        return int'(amp * $sin(x));
    endfunction

endpackage

// File: rtl/dds_wavegen_if.sv
// dds_wavegen_if: control inputs and sample outputs of the waveform generator
interface dds_wavegen_if import dds_pkg::*; #(
    parameter int ACC_W = 16,
    parameter int OUT_W = 8
);
    logic             enable;
    logic [ACC_W-1:0] freq_in;
    logic             freq_load;
    logic [ACC_W-1:0] phase_off;
    mode_t            mode;
    logic [OUT_W-1:0] out;
    logic             out_valid;
    logic             wrap;

    modport master (
        output enable, freq_in, freq_load, phase_off, mode,
        input  out, out_valid, wrap
    );

    modport slave (
        input  enable, freq_in, freq_load, phase_off, mode,
        output out, out_valid, wrap
    );
endinterface

// File: rtl/dds_sine_rom.sv
// dds_sine_rom: quarter-wave sine ROM with registered read data
module dds_sine_rom import dds_pkg::*; #(
    parameter int LUT_AW = 6,
    parameter int OUT_W  = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic [LUT_AW-1:0] addr,
    output logic [OUT_W-2:0]  data
);
    logic [OUT_W-2:0] rom [2**LUT_AW];

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        localparam logic [OUT_W-2:0] V = (OUT_W-1)'(sine_rom_entry(LUT_AW, OUT_W, i));
        assign rom[i] = V;
    end

    // read advances only with the pipeline so a stalled sample keeps its table value
    always_ff @(posedge clk)
        if (en) data <= rom[addr];
endmodule

// File: rtl/dds_wavegen.sv
// dds_wavegen: phase-accumulator DDS with buffered tuning, phase offset and four waveforms
module dds_wavegen import dds_pkg::*; #(
    parameter int ACC_W  = 16,
    parameter int OUT_W  = 8,
    parameter int LUT_AW = 6
) (
    input logic         clock,
    input logic         reset,
    dds_wavegen_if.slave bus
);
    localparam logic [OUT_W-1:0] MID    = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W-1:0] MID_M1 = {1'b0, {(OUT_W-1){1'b1}}};

    logic [ACC_W-1:0]  acc, freq_act, freq_shd, sum, ph, ph_r;
    logic              carry, acc_c, c_r, v1;
    mode_t             mode_r;
    logic [LUT_AW-1:0] addr;
    logic [OUT_W-2:0]  v;
    logic [OUT_W-1:0]  vx, t, sample;
    logic              unused;

    assign {carry, sum} = {1'b0, acc} + {1'b0, freq_act};
    assign ph     = acc + bus.phase_off;
    assign addr   = ph[ACC_W-2] ? ~ph[ACC_W-3 -: LUT_AW] : ph[ACC_W-3 -: LUT_AW];
    assign vx     = {1'b0, v};
    assign t      = ph_r[ACC_W-2 -: OUT_W];
    assign unused = ^ph_r;

    dds_sine_rom #(.LUT_AW(LUT_AW), .OUT_W(OUT_W)) u_rom (
        .clk  (clock),
        .en   (bus.enable),
        .addr (addr),
        .data (v)
    );

    // shadow takes loads any time; active word swaps in at a period boundary, or at once when idle
    always_ff @(posedge clock) begin
        if (reset) begin
            freq_shd <= '0;
            freq_act <= '0;
        end else begin
            if (bus.freq_load) freq_shd <= bus.freq_in;
            if (bus.enable && (carry || freq_act == '0)) freq_act <= freq_shd;
        end
    end

    // accumulator and stage 1; acc_c remembers that the current acc value came from an overflow
    always_ff @(posedge clock) begin
        if (reset) begin
            acc    <= '0;
            acc_c  <= 1'b0;
            ph_r   <= '0;
            mode_r <= MODE_SINE;
            c_r    <= 1'b0;
            v1     <= 1'b0;
        end else begin
            v1 <= bus.enable;
            if (bus.enable) begin
                acc    <= sum;
                acc_c  <= carry;
                ph_r   <= ph;
                mode_r <= bus.mode;
                c_r    <= acc_c;
            end
        end
    end

    // waveform select from the stage-1 phase and the ROM word
    always_comb begin
        sample = mode_r == MODE_SAW ? ph_r[ACC_W-1 -: OUT_W]
               : mode_r == MODE_SQR ? (ph_r[ACC_W-1] ? '0 : '1)
               : mode_r == MODE_TRI ? (ph_r[ACC_W-1] ? ~t : t)
               : (ph_r[ACC_W-1] ? MID_M1 - vx : MID + vx);
    end

    // stage 2: publish a sample only when stage 1 captured one, otherwise hold it
    always_ff @(posedge clock) begin
        if (reset) begin
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.wrap      <= 1'b0;
        end else begin
            bus.out_valid <= v1;
            bus.wrap      <= v1 & c_r;
            if (v1) bus.out <= sample;
        end
    end
endmodule
